cmd_processor_param: RTL and testbench

CMD_PROCESSOR_PARAM -- requirements
Module: cmd_processor_param

---
 rtl/cmd_processor_param_if.sv | 31 +++
 rtl/cmd_processor_param.sv | 203 ++++++++++++++++++++
 tb/tb_cmd_processor_param.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_processor_param_if.sv
// UART byte-stream handshake between a host-side UART and cmd_processor_param.
// Signals:
//   rxReady  one-cycle strobe, rxData holds a received byte
//   rxData   received byte
//   txBusy   transmitter busy
//   txStart  one-cycle strobe, launch txData
//   txData   byte to transmit
// The slave modport is the command processor; master is the UART side.
interface cmd_processor_param_if;
  logic       rxReady;
  logic [7:0] rxData;
  logic       txBusy;
  logic       txStart;
  logic [7:0] txData;

  modport slave (
    input  rxReady,
    input  rxData,
    input  txBusy,
    output txStart,
    output txData
  );

  modport master (
    output rxReady,
    output rxData,
    output txBusy,
    input  txStart,
    input  txData
  );
endinterface

// File: rtl/cmd_processor_param.sv
// Byte-oriented command processor behind a UART: version query, configuration
// register write/read, histogram snapshot dump with clear, error-count query.
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   uart       UART handshake (cmd_processor_param_if.slave)
//   histos     flattened histograms, channel k at [k*HIST_W +: HIST_W]
//   resethist  one-cycle pulse clearing the histograms
//   regs       flattened configuration registers, register k at [k*32 +: 32]
//   reg_wr     one-cycle write strobe per register
//   err_count  saturating count of rejected commands
// Optional feature: define CMD_TIMEOUT_EN to abandon a partial command after
// TIMEOUT idle cycles in argument collection.
module cmd_processor_param #(
  parameter int unsigned NHIST   = 8,
  parameter int unsigned HIST_W  = 32,
  parameter int unsigned NREG    = 8,
  parameter int unsigned VERSION = 8,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic                      clk,
  input  logic                      reset_n,
  cmd_processor_param_if.slave      uart,
  input  logic [NHIST*HIST_W-1:0]   histos,
  output logic                      resethist,
  output logic [NREG*32-1:0]        regs,
  output logic [NREG-1:0]           reg_wr,
  output logic [7:0]                err_count
);

  localparam int unsigned HIST_BITS = NHIST * HIST_W;
  localparam int unsigned NBYTES    = HIST_BITS / 8;
  localparam int unsigned MAXB      = (NBYTES > 4) ? NBYTES : 4;
  localparam int unsigned CNT_W     = $clog2(MAXB + 1);
  localparam int unsigned TXB_W     = (HIST_BITS > 32) ? HIST_BITS : 32;

  localparam logic [7:0] OP_VER  = 8'h00;
  localparam logic [7:0] OP_WR   = 8'h01;
  localparam logic [7:0] OP_RD   = 8'h02;
  localparam logic [7:0] OP_HIST = 8'h03;
  localparam logic [7:0] OP_ERR  = 8'h04;

  typedef enum logic [2:0] {IDLE, ARGS, EXEC, SNAP, TX_LOAD, TX_WAIT} state_t;

  state_t             state;
  logic [7:0]         opcode;
  logic [7:0]         args [5];
  logic [2:0]         arg_cnt;
  logic [2:0]         arg_need;
  logic [TXB_W-1:0]   txbuf;
  logic [CNT_W-1:0]   tx_cnt;
  logic [CNT_W-1:0]   tx_total;

`ifdef CMD_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0]   tmo_cnt;
`endif

  // Number of argument bytes following each opcode.
  function automatic logic [2:0] args_for(input logic [7:0] op);
    case (op)
      OP_WR:   return 3'd5;
      OP_RD:   return 3'd1;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Register read mux and index range check on args[0].
  logic [31:0] rd_word_c;
  logic        idx_ok_c;
  logic [31:0] wr_word_c;

  always_comb begin
    rd_word_c = '0;
    idx_ok_c  = 32'(args[0]) < NREG;
    wr_word_c = {args[4], args[3], args[2], args[1]};
    for (int k = 0; k < NREG; k++) begin
      if (args[0] == 8'(k)) rd_word_c = regs[k*32 +: 32];
    end
  end

  // Command FSM with registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      uart.txStart <= 1'b0;
      uart.txData  <= '0;
      resethist    <= 1'b0;
      regs         <= '0;
      reg_wr       <= '0;
      err_count    <= '0;
      opcode       <= '0;
      arg_cnt      <= '0;
      arg_need     <= '0;
      txbuf        <= '0;
      tx_cnt       <= '0;
      tx_total     <= '0;
      for (int k = 0; k < 5; k++) args[k] <= '0;
`ifdef CMD_TIMEOUT_EN
      tmo_cnt      <= '0;
`endif
    end else begin
      uart.txStart <= 1'b0;
      resethist    <= 1'b0;
      reg_wr       <= '0;
      case (state)
        IDLE: begin
          if (uart.rxReady) begin
            opcode   <= uart.rxData;
            arg_cnt  <= '0;
            arg_need <= args_for(uart.rxData);
`ifdef CMD_TIMEOUT_EN
            tmo_cnt  <= '0;
`endif
            state    <= (args_for(uart.rxData) == 3'd0) ? EXEC : ARGS;
          end
        end
        ARGS: begin
          if (uart.rxReady) begin
            args[arg_cnt] <= uart.rxData;
            arg_cnt       <= arg_cnt + 3'd1;
`ifdef CMD_TIMEOUT_EN
            tmo_cnt       <= '0;
`endif
            if (arg_cnt == arg_need - 3'd1) state <= EXEC;
          end
`ifdef CMD_TIMEOUT_EN
          else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
            err_count <= sat_inc(err_count);
            state     <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
`endif
        end
        EXEC: begin
          tx_cnt <= '0;
          case (opcode)
            OP_VER: begin
              txbuf    <= TXB_W'(8'(VERSION));
              tx_total <= CNT_W'(1);
              state    <= TX_LOAD;
            end
            OP_WR: begin
              for (int k = 0; k < NREG; k++) begin
                if (args[0] == 8'(k)) begin
                  regs[k*32 +: 32] <= wr_word_c;
                  reg_wr[k]        <= 1'b1;
                end
              end
              if (!idx_ok_c) err_count <= sat_inc(err_count);
              state <= IDLE;
            end
            OP_RD: begin
              // rd_word_c is already zero for an out-of-range index.
              txbuf    <= TXB_W'(rd_word_c);
              tx_total <= CNT_W'(4);
              if (!idx_ok_c) err_count <= sat_inc(err_count);
              state    <= TX_LOAD;
            end
            OP_HIST: begin
              txbuf    <= TXB_W'(histos);
              tx_total <= CNT_W'(NBYTES);
              state    <= SNAP;
            end
            OP_ERR: begin
              txbuf    <= TXB_W'(err_count);
              tx_total <= CNT_W'(1);
              state    <= TX_LOAD;
            end
            default: begin
              err_count <= sat_inc(err_count);
              state     <= IDLE;
            end
          endcase
        end
        SNAP: begin
          resethist <= 1'b1;
          state     <= TX_LOAD;
        end
        TX_LOAD: begin
          if (!uart.txBusy) begin
            uart.txData  <= txbuf[7:0];
            uart.txStart <= 1'b1;
            txbuf        <= txbuf >> 8;
            tx_cnt       <= tx_cnt + CNT_W'(1);
            state        <= TX_WAIT;
          end
        end
        TX_WAIT: begin
          // Wait for the UART to accept the byte before moving on.
          if (uart.txBusy) state <= (tx_cnt == tx_total) ? IDLE : TX_LOAD;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_processor_param.sv
// Directed bench for cmd_processor_param: a UART model captures transmitted
// bytes, expected replies are queued as commands are sent and compared in order.
module tb_cmd_processor_param;
  localparam int unsigned NH  = 2;
  localparam int unsigned HW  = 16;
  localparam int unsigned NR  = 8;
  localparam int unsigned VER = 'h5A;
  localparam int unsigned TMO = 100;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [NH*HW-1:0]   histos;
  logic               resethist;
  logic [NR*32-1:0]   regs;
  logic [NR-1:0]      reg_wr;
  logic [7:0]         err_count;

  cmd_processor_param_if u_if ();

  cmd_processor_param #(
    .NHIST(NH), .HIST_W(HW), .NREG(NR), .VERSION(VER), .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .uart(u_if.slave),
    .histos(histos),
    .resethist(resethist),
    .regs(regs),
    .reg_wr(reg_wr),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  logic [7:0]       got [$];
  logic [7:0]       exp_q [$];
  int               checks = 0;
  int               fails = 0;
  int               tx_starts = 0;
  int               wr_pulses = 0;
  int               rh_pulses = 0;
  logic [NR-1:0]    last_wr = '0;
  logic [NR*32-1:0] regs_at_wr = '0;
  int               exp_err = 0;

  // UART transmitter model: capture each launched byte, then stay busy a while.
  initial begin
    u_if.txBusy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (u_if.txStart) begin
        got.push_back(u_if.txData);
        tx_starts++;
        u_if.txBusy = 1'b1;
        repeat (3) @(posedge clk);
        #1 u_if.txBusy = 1'b0;
      end
    end
  end

  // Pulse monitor for register writes and histogram clear.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (reg_wr != '0) begin
        wr_pulses++;
        last_wr    = reg_wr;
        regs_at_wr = regs;
      end
      if (resethist) rh_pulses++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    u_if.rxData  = b;
    u_if.rxReady = 1'b1;
    @(negedge clk);
    u_if.rxReady = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (got.size() < exp_q.size() && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (20) @(negedge clk);
    chk({tag, " byte count"}, 64'(got.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && got.size() > 0)
      chk(tag, 64'(got.pop_front()), 64'(exp_q.pop_front()));
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [31:0] hv;
    int          wr0;
    int          rh0;
    int          st0;
    int          n;

    reset_n      = 1'b1;
    u_if.rxReady = 1'b0;
    u_if.rxData  = '0;
    histos       = '0;
    #2 reset_n = 1'b0;
    #1;
    chk("reset txStart", 64'(u_if.txStart), 64'(0));
    chk("reset txData", 64'(u_if.txData), 64'(0));
    chk("reset resethist", 64'(resethist), 64'(0));
    chk("reset regs", 64'(regs[63:0] | regs[NR*32-1:NR*32-64]), 64'(0));
    chk("reset reg_wr", 64'(reg_wr), 64'(0));
    chk("reset err_count", 64'(err_count), 64'(0));
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Version query.
    st0 = tx_starts;
    send(8'h00);
    exp_q.push_back(8'(VER));
    drain("version");
    chk("version txStart count", 64'(tx_starts - st0), 64'(1));

    // Register write then read-back.
    wr0 = wr_pulses;
    send(8'h01); send(8'h03); send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    repeat (5) @(negedge clk);
    chk("write pulses", 64'(wr_pulses - wr0), 64'(1));
    chk("write strobe", 64'(last_wr), 64'(8'h08));
    chk("write data with strobe", 64'(regs_at_wr[3*32 +: 32]), 64'(32'h12345678));
    chk("reg3 held", 64'(regs[3*32 +: 32]), 64'(32'h12345678));
    send(8'h02); send(8'h03);
    exp_q.push_back(8'h78); exp_q.push_back(8'h56);
    exp_q.push_back(8'h34); exp_q.push_back(8'h12);
    drain("read reg3");

    // Highest legal index.
    send(8'h01); send(8'h07); send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
    repeat (5) @(negedge clk);
    chk("write strobe reg7", 64'(last_wr), 64'(8'h80));
    send(8'h02); send(8'h07);
    exp_q.push_back(8'hEF); exp_q.push_back(8'hBE);
    exp_q.push_back(8'hAD); exp_q.push_back(8'hDE);
    drain("read reg7");

    // Histogram dump; inputs change after the snapshot.
    hv     = 32'hBBBBAAAA;
    histos = hv;
    rh0    = rh_pulses;
    send(8'h03);
    for (int i = 0; i < 4; i++) exp_q.push_back(hv[8*i +: 8]);
    n = 0;
    while (rh_pulses == rh0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    histos = 32'h12345678;
    drain("hist dump");
    chk("resethist pulses", 64'(rh_pulses - rh0), 64'(1));

    // Rejected commands.
    wr0 = wr_pulses;
    send(8'h01); send(8'h09); send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    exp_err++;
    repeat (5) @(negedge clk);
    chk("bad write no strobe", 64'(wr_pulses - wr0), 64'(0));
    send(8'h7F);
    exp_err++;
    repeat (5) @(negedge clk);
    chk("err after bad opcode", 64'(err_count), 64'(exp_err));
    send(8'h04);
    exp_q.push_back(8'h02);
    drain("err query");
    send(8'h02); send(8'h09);
    exp_err++;
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h00);
    drain("bad read");
    chk("err after bad read", 64'(err_count), 64'(exp_err));

    // Byte arriving while a reply is underway is dropped.
    send(8'h04);
    send(8'h00);
    exp_q.push_back(8'(exp_err));
    drain("drop during tx");

`ifdef CMD_TIMEOUT_EN
    send(8'h01); send(8'h02);
    repeat (TMO + 20) @(negedge clk);
    exp_err++;
    chk("timeout err", 64'(err_count), 64'(exp_err));
    send(8'h00);
    exp_q.push_back(8'(VER));
    drain("version after timeout");
`else
    send(8'h01); send(8'h02);
    repeat (150) @(negedge clk);
    chk("no timeout err", 64'(err_count), 64'(exp_err));
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    repeat (5) @(negedge clk);
    chk("late args write", 64'(regs[2*32 +: 32]), 64'(32'h44332211));
    send(8'h02); send(8'h02);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    drain("read reg2");
`endif

    // Reset during the second byte of a dump.
    hv     = 32'hD4C3B2A1;
    histos = hv;
    send(8'h03);
    n = 0;
    while (got.size() < 1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("dump first byte", 64'(got.size() > 0 ? got[0] : 8'hXX), 64'(hv[7:0]));
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midreset txStart", 64'(u_if.txStart), 64'(0));
    chk("midreset txData", 64'(u_if.txData), 64'(0));
    chk("midreset resethist", 64'(resethist), 64'(0));
    chk("midreset reg3", 64'(regs[3*32 +: 32]), 64'(0));
    chk("midreset err_count", 64'(err_count), 64'(0));
    repeat (3) @(negedge clk);
    st0 = tx_starts;
    rh0 = rh_pulses;
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("no txStart after reset", 64'(tx_starts - st0), 64'(0));
    chk("no resethist after reset", 64'(rh_pulses - rh0), 64'(0));
    got.delete();
    exp_q.delete();
    send(8'h00);
    exp_q.push_back(8'(VER));
    drain("version after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
